regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (Write1/WriteReg1/WriteData1) among NREQ writeback sources, for example ALU, load unit and mult/div.
- Each source offers a writeback with a valid/ready handshake. The arbiter grants at most one source per cycle and drives the write port from a registered output stage.
- Fixed priority with starvation escalation is the default arbitration. Round-robin is compile-time selectable.

---
 rtl/regfile_wb_arbiter_if.sv | 59 +++++
 rtl/regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
//-----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//
// Purpose:
//   Bundles the writeback request side and the register-file write port of
//   regfile_wb_arbiter into one interface. The arbiter connects through the
//   slave modport. The writeback sources / test environment connect through
//   the master modport.
//
// Signals:
//   ReqValid   [NREQ]     per-source writeback request
//   ReqReg     [5*NREQ]   destination register of source i, bits [5i+4:5i]
//   ReqData    [32*NREQ]  write data of source i, bits [32i+31:32i]
//   ReqReady   [NREQ]     one-hot grant (combinational)
//   WbHold     [1]        freeze: no grants while high
//   Write1     [1]        register-file write enable (registered)
//   WriteReg1  [5]        register-file write address (registered)
//   WriteData1 [32]       register-file write data (registered)
//   Starved    [1]        high in a cycle that issues a forced grant
//-----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    ReqValid;
    logic [5*NREQ-1:0]  ReqReg;
    logic [32*NREQ-1:0] ReqData;
    logic [NREQ-1:0]    ReqReady;
    logic               WbHold;
    logic               Write1;
    logic [4:0]         WriteReg1;
    logic [31:0]        WriteData1;
    logic               Starved;

    // Writeback sources drive requests and observe grants / write port
    modport master (
        output ReqValid,
        output ReqReg,
        output ReqData,
        output WbHold,
        input  ReqReady,
        input  Write1,
        input  WriteReg1,
        input  WriteData1,
        input  Starved
    );

    // Arbiter consumes requests and drives grants / write port
    modport slave (
        input  ReqValid,
        input  ReqReg,
        input  ReqData,
        input  WbHold,
        output ReqReady,
        output Write1,
        output WriteReg1,
        output WriteData1,
        output Starved
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
//-----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the register file's single write port among NREQ writeback
//   sources (ALU, load unit, mult/div, ...). At most one source is granted
//   per cycle. The granted writeback appears on the registered write port
//   one edge later.
//
//   Default build: fixed priority (index 0 highest) with starvation
//   escalation. A valid source that has waited STARVE_LIMIT or more
//   consecutive cycles is force-granted, and Starved is raised in that
//   cycle.
//
//   Compile-time option WB_RR_ARB_EN: round-robin arbitration replaces
//   fixed priority. The wait counters and escalation are removed, and
//   Starved is tied low.
//
// Parameters:
//   NREQ          number of writeback requesters (2..8)
//   STARVE_LIMIT  wait cycles before a forced grant (1..255)
//
// Ports:
//   CLK    in  clock, rising edge
//   RESET  in  synchronous active-high reset
//   wb     regfile_wb_arbiter_if.slave (request bus + write port)
//-----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                 CLK,
    input  logic                 RESET,
    regfile_wb_arbiter_if.slave  wb
);

    localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int REGW  = 5;
    localparam int DATAW = 32;

    // Common arbitration results
    logic [NREQ-1:0]  grant_s;
    logic [IDXW-1:0]  grantIdx_s;
    logic             grantAny_s;
    logic             forced_s;

    // Payload of the granted source
    logic [REGW-1:0]  selReg_s;
    logic [DATAW-1:0] selData_s;

    // Registered write port
    logic             Write1_r;
    logic [REGW-1:0]  WriteReg1_r;
    logic [DATAW-1:0] WriteData1_r;

    // Returns the index of the lowest set bit (0 when none is set).
    // Scanning downward lets the last hit, the lowest index, win.
    function automatic logic [IDXW-1:0] lowestIdx(input logic [NREQ-1:0] vec);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    // Expands an index into a one-hot vector
    function automatic logic [NREQ-1:0] oneHot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = {NREQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

`ifndef WB_RR_ARB_EN
    //-------------------------------------------------------------------------
    // Fixed priority with starvation escalation
    //-------------------------------------------------------------------------
    localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
    localparam logic [7:0] CNT_MAX     = 8'hFF;

    logic [7:0]      waitCnt_r [NREQ];
    logic [NREQ-1:0] starveVec_s;

    // Flags every valid source that has waited at least the starvation limit
    always_comb begin
        starveVec_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            starveVec_s[i] = wb.ReqValid[i] && (waitCnt_r[i] >= STARVE_LIM8);
        end
    end

    // Selects one source: starved sources first, then plain fixed priority
    always_comb begin
        grantIdx_s = {IDXW{1'b0}};
        grantAny_s = 1'b0;
        forced_s   = 1'b0;
        if (RESET || wb.WbHold || (wb.ReqValid == {NREQ{1'b0}})) begin
            grantAny_s = 1'b0;
        end else if (starveVec_s != {NREQ{1'b0}}) begin
            grantAny_s = 1'b1;
            forced_s   = 1'b1;
            grantIdx_s = lowestIdx(starveVec_s);
        end else begin
            grantAny_s = 1'b1;
            grantIdx_s = lowestIdx(wb.ReqValid);
        end
    end

    // Per-source saturating wait counters. WbHold freezes them entirely, so
    // a hold window never counts toward starvation.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (RESET) begin
                waitCnt_r[i] <= 8'd0;
            end else if (wb.WbHold) begin
                waitCnt_r[i] <= waitCnt_r[i];
            end else if (!wb.ReqValid[i] || grant_s[i]) begin
                waitCnt_r[i] <= 8'd0;
            end else if (waitCnt_r[i] != CNT_MAX) begin
                waitCnt_r[i] <= waitCnt_r[i] + 8'd1;
            end else begin
                waitCnt_r[i] <= waitCnt_r[i];
            end
        end
    end
`else
    //-------------------------------------------------------------------------
    // Round-robin arbitration
    //-------------------------------------------------------------------------
    localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(32'd1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

    logic [IDXW-1:0] rrPtr_r;
    int              rrCand_s;

    // Grants the first valid source at or after the pointer, wrapping
    always_comb begin
        grantIdx_s = {IDXW{1'b0}};
        grantAny_s = 1'b0;
        forced_s   = 1'b0;
        rrCand_s   = 0;
        if (RESET || wb.WbHold || (wb.ReqValid == {NREQ{1'b0}})) begin
            grantAny_s = 1'b0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                rrCand_s = int'(rrPtr_r) + k;
                if (rrCand_s >= NREQ) begin
                    rrCand_s = rrCand_s - NREQ;
                end else begin
                    rrCand_s = rrCand_s;
                end
                if (!grantAny_s && wb.ReqValid[rrCand_s]) begin
                    grantAny_s = 1'b1;
                    grantIdx_s = IDXW'(rrCand_s);
                end else begin
                    grantAny_s = grantAny_s;
                end
            end
        end
    end

    // Advances the pointer past the granted source; no grant leaves it alone
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rrPtr_r <= {IDXW{1'b0}};
        end else if (grantAny_s) begin
            if (grantIdx_s == LAST_IDX) begin
                rrPtr_r <= {IDXW{1'b0}};
            end else begin
                rrPtr_r <= grantIdx_s + ONE_IDX;
            end
        end else begin
            rrPtr_r <= rrPtr_r;
        end
    end
`endif

    assign grant_s = grantAny_s ? oneHot(grantIdx_s) : {NREQ{1'b0}};

    // Picks the granted source's destination and data off the flat buses
    always_comb begin
        selReg_s  = wb.ReqReg[int'(grantIdx_s) * REGW +: REGW];
        selData_s = wb.ReqData[int'(grantIdx_s) * DATAW +: DATAW];
    end

    // Registered write port. A writeback to r0 is consumed and its address
    // and data are captured, but the write enable stays low so r0 is never
    // written.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Write1_r     <= 1'b0;
            WriteReg1_r  <= 5'd0;
            WriteData1_r <= 32'd0;
        end else if (grantAny_s) begin
            Write1_r     <= (selReg_s != 5'd0);
            WriteReg1_r  <= selReg_s;
            WriteData1_r <= selData_s;
        end else begin
            Write1_r     <= 1'b0;
            WriteReg1_r  <= WriteReg1_r;
            WriteData1_r <= WriteData1_r;
        end
    end

    assign wb.ReqReady   = grant_s;
    assign wb.Starved    = forced_s;
    assign wb.Write1     = Write1_r;
    assign wb.WriteReg1  = WriteReg1_r;
    assign wb.WriteData1 = WriteData1_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
//-----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter (NREQ=3, STARVE_LIMIT=7).
// A behavioural model (integer wait counts, integer RR pointer, expected
// write port) predicts each cycle's grant and the following write.
// Build with +define+WB_RR_ARB_EN to check the round-robin variant.
//-----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int N     = 3;
    localparam int LIMIT = 7;

    logic CLK;
    logic RESET;

    regfile_wb_arbiter_if #(.NREQ(N)) wbIf ();

    regfile_wb_arbiter #(.NREQ(N), .STARVE_LIMIT(LIMIT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .wb    (wbIf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          mCnt [N];
    int          mPtr;
    logic        mW;
    logic [4:0]  mReg;
    logic [31:0] mData;

    // Per-cycle prediction and observation
    int          expIdx;
    logic [N-1:0] expGnt;
    logic        expStv;
    logic [N-1:0] obsGnt;
    logic        obsStv;

    // Source payloads
    logic [4:0]  srcReg  [N];
    logic [31:0] srcData [N];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic drive(input logic [N-1:0] v, input logic hold);
        wbIf.ReqValid = v;
        wbIf.WbHold   = hold;
        for (int i = 0; i < N; i++) begin
            wbIf.ReqReg[i*5 +: 5]   = srcReg[i];
            wbIf.ReqData[i*32 +: 32] = srcData[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mCnt[i] = 0;
        mPtr  = 0;
        mW    = 1'b0;
        mReg  = 5'd0;
        mData = 32'd0;
    endtask

    task automatic model_predict(input logic [N-1:0] v, input logic hold);
        expIdx = -1;
        expStv = 1'b0;
        if (!hold && v != '0) begin
`ifdef WB_RR_ARB_EN
            for (int k = 0; k < N; k++)
                if (expIdx < 0 && v[(mPtr + k) % N]) expIdx = (mPtr + k) % N;
`else
            for (int i = 0; i < N; i++)
                if (expIdx < 0 && v[i] && mCnt[i] >= LIMIT) expIdx = i;
            if (expIdx >= 0) expStv = 1'b1;
            else
                for (int i = 0; i < N; i++)
                    if (expIdx < 0 && v[i]) expIdx = i;
`endif
        end
        expGnt = (expIdx >= 0) ? (N'(1) << expIdx) : '0;
    endtask

    task automatic model_commit(input logic [N-1:0] v, input logic hold);
        if (!hold) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] || expIdx == i) mCnt[i] = 0;
                else if (mCnt[i] < 255) mCnt[i] = mCnt[i] + 1;
            end
        end
        if (expIdx >= 0) begin
            mPtr  = (expIdx + 1) % N;
            mW    = (srcReg[expIdx] != 5'd0);
            mReg  = srcReg[expIdx];
            mData = srcData[expIdx];
        end else begin
            mW = 1'b0;
        end
    endtask

    // One cycle: drive after an edge, observe grant mid-cycle, then cross the edge
    task automatic step(input logic [N-1:0] v, input logic hold);
        drive(v, hold);
        #4;
        obsGnt = wbIf.ReqReady;
        obsStv = wbIf.Starved;
        model_predict(v, hold);
        @(posedge CLK);
        #1;
        model_commit(v, hold);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive('0, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcReg[i]  = 5'(i + 1);
            srcData[i] = 32'hA5A5_0000 + i;
        end
        drive(3'b111, 1'b0);
        #4;
        checks++;
        if (wbIf.ReqReady !== 3'b000) begin
            failures++;
            $display("FAIL reset_ready: got %b want 000", wbIf.ReqReady);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (wbIf.Write1 !== 1'b0 || wbIf.WriteReg1 !== 5'd0 || wbIf.WriteData1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: got W=%b R=%0d D=%h want 0/0/0",
                     wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1);
        end
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_hold();
        srcReg[0]  = 5'd3;
        srcData[0] = 32'h0AAA_0001;
        for (int c = 0; c < 4; c++) begin
            step(3'b101, 1'b1);
            checks++;
            if (obsGnt !== 3'b000 || wbIf.Write1 !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: got ready=%b W=%b want 000/0", c, obsGnt, wbIf.Write1);
            end
        end
        step(3'b101, 1'b0);
        checks++;
        if (obsGnt !== 3'b001) begin
            failures++;
            $display("FAIL hold_release_grant: got %b want 001", obsGnt);
        end
        checks++;
        if (wbIf.Write1 !== 1'b1 || wbIf.WriteReg1 !== 5'd3 || wbIf.WriteData1 !== 32'h0AAA_0001) begin
            failures++;
            $display("FAIL hold_release_write: got W=%b R=%0d D=%h want 1/3/0aaa0001",
                     wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1);
        end
    endtask

    task automatic test_single();
        srcReg[1]  = 5'd5;
        srcData[1] = 32'hDEAD_BEEF;
        step(3'b010, 1'b0);
        checks++;
        if (obsGnt !== 3'b010) begin
            failures++;
            $display("FAIL single_grant: got %b want 010", obsGnt);
        end
        checks++;
        if (wbIf.Write1 !== 1'b1 || wbIf.WriteReg1 !== 5'd5 || wbIf.WriteData1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_write: got W=%b R=%0d D=%h want 1/5/deadbeef",
                     wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1);
        end
        step(3'b000, 1'b0);
        checks++;
        if (wbIf.Write1 !== 1'b0 || wbIf.WriteReg1 !== 5'd5 || wbIf.WriteData1 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_idle: got W=%b R=%0d D=%h want 0/5/deadbeef",
                     wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1);
        end
    endtask

    task automatic test_reg0();
        srcReg[2]  = 5'd0;
        srcData[2] = 32'h0000_1234;
        step(3'b100, 1'b0);
        checks++;
        if (obsGnt !== 3'b100) begin
            failures++;
            $display("FAIL reg0_grant: got %b want 100", obsGnt);
        end
        checks++;
        if (wbIf.Write1 !== 1'b0 || wbIf.WriteReg1 !== 5'd0 || wbIf.WriteData1 !== 32'h0000_1234) begin
            failures++;
            $display("FAIL reg0_write: got W=%b R=%0d D=%h want 0/0/00001234",
                     wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1);
        end
    endtask

`ifndef WB_RR_ARB_EN
    task automatic test_starvation();
        logic [N-1:0] want;
        do_reset();
        srcReg[0] = 5'd7;  srcData[0] = 32'h1111_0000;
        srcReg[2] = 5'd9;  srcData[2] = 32'h2222_0000;
        for (int c = 0; c < 9; c++) begin
            step(3'b101, 1'b0);
            want = (c == 7) ? 3'b100 : 3'b001;
            checks++;
            if (obsGnt !== want || obsStv !== (c == 7)) begin
                failures++;
                $display("FAIL starve_cycle%0d: got ready=%b starved=%b want %b/%b",
                         c, obsGnt, obsStv, want, (c == 7));
            end
            if (c == 7) begin
                checks++;
                if (wbIf.WriteData1 !== 32'h2222_0000 || wbIf.WriteReg1 !== 5'd9) begin
                    failures++;
                    $display("FAIL starve_write: got R=%0d D=%h want 9/22220000",
                             wbIf.WriteReg1, wbIf.WriteData1);
                end
            end
        end
    endtask
`else
    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step(3'b111, 1'b0);
            want = N'(1) << (c % N);
            checks++;
            if (obsGnt !== want || obsStv !== 1'b0) begin
                failures++;
                $display("FAIL rr_cycle%0d: got ready=%b starved=%b want %b/0", c, obsGnt, obsStv, want);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                srcReg[i]  = 5'(8 + i);
                srcData[i] = 32'hB000_0000 + (c << 4) + i;
            end
            step(3'b111, 1'b0);
            checks++;
            if (obsGnt !== expGnt || wbIf.Write1 !== 1'b1 || wbIf.WriteData1 !== mData) begin
                failures++;
                $display("FAIL b2b_cycle%0d: got ready=%b W=%b D=%h want %b/1/%h",
                         c, obsGnt, wbIf.Write1, wbIf.WriteData1, expGnt, mData);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        srcReg[1] = 5'd11; srcData[1] = 32'h3333_0001;
        srcReg[2] = 5'd12; srcData[2] = 32'h3333_0002;
        for (int c = 0; c < 4; c++) begin
            step(3'b110, 1'b0);
            checks++;
            if (obsGnt !== expGnt) begin
                failures++;
                $display("FAIL midrst_pre%0d: got %b want %b", c, obsGnt, expGnt);
            end
        end
        srcReg[1]  = 5'd9;
        srcData[1] = 32'h0000_AAAA;
        drive(3'b010, 1'b0);
        #4;
        checks++;
        if (wbIf.ReqReady !== 3'b010) begin
            failures++;
            $display("FAIL midrst_grant: got %b want 010", wbIf.ReqReady);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (wbIf.ReqReady !== 3'b000) begin
            failures++;
            $display("FAIL midrst_ready_forced: got %b want 000", wbIf.ReqReady);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (wbIf.Write1 !== 1'b0 || wbIf.WriteReg1 !== 5'd0 || wbIf.WriteData1 !== 32'd0) begin
            failures++;
            $display("FAIL midrst_outputs: got W=%b R=%0d D=%h want 0/0/0",
                     wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1);
        end
        RESET = 1'b0;
        model_reset();
        srcReg[0] = 5'd4; srcData[0] = 32'h4444_0000;
        for (int c = 0; c < 9; c++) begin
            step(3'b101, 1'b0);
            if (c == 0) begin
                checks++;
                if (obsGnt !== 3'b001) begin
                    failures++;
                    $display("FAIL midrst_first: got %b want 001", obsGnt);
                end
            end
            checks++;
            if (obsGnt !== expGnt || obsStv !== expStv) begin
                failures++;
                $display("FAIL midrst_post%0d: got ready=%b starved=%b want %b/%b",
                         c, obsGnt, obsStv, expGnt, expStv);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic         hold;
        do_reset();
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i]    = 1'b1;
                        srcReg[i]  = 5'($urandom_range(0, 31));
                        srcData[i] = $urandom();
                    end
                end else if (!hold && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            step(pend, hold);
            checks++;
            if (obsGnt !== expGnt || obsStv !== expStv) begin
                failures++;
                $display("FAIL rand_grant c%0d: got ready=%b starved=%b want %b/%b",
                         c, obsGnt, obsStv, expGnt, expStv);
            end
            checks++;
            if (wbIf.Write1 !== mW || wbIf.WriteReg1 !== mReg || wbIf.WriteData1 !== mData) begin
                failures++;
                $display("FAIL rand_write c%0d: got W=%b R=%0d D=%h want %b/%0d/%h",
                         c, wbIf.Write1, wbIf.WriteReg1, wbIf.WriteData1, mW, mReg, mData);
            end
            if (expIdx >= 0) pend[expIdx] = 1'b0;
        end
    endtask

    initial begin
        RESET = 1'b1;
        for (int i = 0; i < N; i++) begin
            srcReg[i]  = 5'd0;
            srcData[i] = 32'd0;
        end
        drive('0, 1'b0);
        model_reset();
        @(posedge CLK);
        #1;
        test_reset();
        test_hold();
        test_single();
        test_reg0();
`ifndef WB_RR_ARB_EN
        test_starvation();
`else
        test_round_robin();
`endif
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
